// File: rtl/fpd_iter_pkg.sv
// fpd_iter_pkg: shared constants, flag indices and FSM state encoding for the
// iterative single-precision divider.
package fpd_iter_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int WORD_W = 1 + EXP_W + MAN_W;

    // Quotient bits produced by the divider: hidden bit, MAN_W fraction bits, guard, one extra
    localparam int QW    = MAN_W + 3;
    // Working exponent width: two extra bits so under/overflow stay representable
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = 5;

    localparam logic [WORD_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [WORD_W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [EW-1:0]     EXP_MAX = EW'((1 << EXP_W) - 1);

    // Bit positions inside the {nv,dz,of,uf} flag vector
    localparam int FLAG_NV = 3;
    localparam int FLAG_DZ = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_UF = 0;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fpd_iter_if.sv
// fpd_iter_if: valid/ready operand and result bundle of the divider.
// master drives operands and consumes results; slave is the divider.
interface fpd_iter_if;
    import fpd_iter_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] c;
    logic [3:0]        flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );

endinterface

// File: rtl/fpd_iter_classify.sv
// fpd_iter_classify: combinational operand classifier. Denormals (exp=0) are
// reported as zero; the mantissa output carries the hidden bit.
module fpd_iter_classify
    import fpd_iter_pkg::*;
(
    input  logic [WORD_W-1:0] op_i,
    output logic              is_nan_o,
    output logic              is_inf_o,
    output logic              is_zero_o,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MAN_W:0]    man_o
);

    logic expAllOnes;
    logic fracZero;

    assign sign_o     = op_i[WORD_W-1];
    assign exp_o      = op_i[WORD_W-2:MAN_W];
    assign man_o      = {1'b1, op_i[MAN_W-1:0]};
    assign expAllOnes = &op_i[WORD_W-2:MAN_W];
    assign fracZero   = (op_i[MAN_W-1:0] == '0);
    assign is_zero_o  = (op_i[WORD_W-2:MAN_W] == '0);
    assign is_inf_o   = expAllOnes & fracZero;
    assign is_nan_o   = expAllOnes & ~fracZero;

endmodule

// File: rtl/fpd_iter.sv
// fpd_iter: iterative single-precision divider, c = a / b.
// Radix-2 restoring division, one quotient bit per clock, one operation in flight.
// Build option: define FPD_ROUND_EN for round-to-nearest-even; default truncates.
module fpd_iter
    import fpd_iter_pkg::*;
(
    input logic       clk,
    input logic       rst,
    fpd_iter_if.slave bus
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [MAN_W+1:0]    rem_q, rem_d;
    logic [MAN_W:0]      div_q, div_d;
    logic [QW-1:0]       quot_q, quot_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic [WORD_W-1:0]   c_q, c_d;
    logic [3:0]          flags_q, flags_d;

    logic                aNan, aInf, aZero, aSign;
    logic                bNan, bInf, bZero, bSign;
    logic [EXP_W-1:0]    aExp, bExp;
    logic [MAN_W:0]      aMan, bMan;
    logic                resSign;

    logic [MAN_W+2:0]    trial;
    logic                qBit;
    logic [MAN_W:0]      keptRem;

    logic [QW-1:0]       normQuot;
    logic [EW-1:0]       normExp;
    logic [MAN_W-1:0]    mant;
    logic                roundUp;
    logic [MAN_W:0]      mantRnd;
    logic [EW-1:0]       expRnd;
    logic                expOver;
    logic                expUnder;
    logic                unusedBits;

    fpd_iter_classify uClassA (
        .op_i      (a_q),
        .is_nan_o  (aNan),
        .is_inf_o  (aInf),
        .is_zero_o (aZero),
        .sign_o    (aSign),
        .exp_o     (aExp),
        .man_o     (aMan)
    );

    fpd_iter_classify uClassB (
        .op_i      (b_q),
        .is_nan_o  (bNan),
        .is_inf_o  (bInf),
        .is_zero_o (bZero),
        .sign_o    (bSign),
        .exp_o     (bExp),
        .man_o     (bMan)
    );

    assign resSign = aSign ^ bSign;

    // One restoring step: a clear sign on the trial difference means the divisor fits.
    always_comb begin
        trial   = {1'b0, rem_q} - {2'b00, div_q};
        qBit    = ~trial[MAN_W+2];
        keptRem = qBit ? trial[MAN_W:0] : rem_q[MAN_W:0];
    end

    // Normalise the quotient to 1.f, optionally round, then range-check the rounded exponent.
    always_comb begin
        normQuot = quot_q;
        normExp  = exp_q;
        if (!quot_q[QW-1]) begin
            normQuot = {quot_q[QW-2:0], 1'b0};
            normExp  = exp_q - EW'(1);
        end
        mant = normQuot[QW-2:2];
`ifdef FPD_ROUND_EN
        roundUp = normQuot[1] & (normQuot[0] | (rem_q != '0) | mant[0]);
`else
        roundUp = 1'b0;
`endif
        mantRnd  = {1'b0, mant} + {{MAN_W{1'b0}}, roundUp};
        expRnd   = normExp + {{(EW-1){1'b0}}, mantRnd[MAN_W]};
        expOver  = ~expRnd[EW-1] & (expRnd >= EXP_MAX);
        expUnder = expRnd[EW-1] | (expRnd == '0);
    end

    // The leading quotient bit is always 1 after normalisation and the trial's
    // second bit never survives a restore, so these bits carry no information.
`ifdef FPD_ROUND_EN
    assign unusedBits = normQuot[QW-1] ^ trial[MAN_W+1];
`else
    assign unusedBits = ^{normQuot[QW-1], normQuot[1:0], trial[MAN_W+1]};
`endif

    // Next state and datapath loads: accept, classify, iterate, pack, hand off.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quot_d  = quot_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        c_d     = c_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = resSign;
                flags_d = '0;
                if (aNan | bNan | (aZero & bZero) | (aInf & bInf)) begin
                    c_d              = QNAN;
                    flags_d[FLAG_NV] = 1'b1;
                    state_d          = DONE;
                end else if (aInf) begin
                    c_d     = {resSign, INF_MAG};
                    state_d = DONE;
                end else if (bZero) begin
                    c_d              = {resSign, INF_MAG};
                    flags_d[FLAG_DZ] = 1'b1;
                    state_d          = DONE;
                end else if (aZero | bInf) begin
                    c_d     = {resSign, {(WORD_W-1){1'b0}}};
                    state_d = DONE;
                end else begin
                    rem_d   = {1'b0, aMan};
                    div_d   = bMan;
                    quot_d  = '0;
                    cnt_d   = '0;
                    exp_d   = {2'b00, aExp} - {2'b00, bExp} + EW'(BIAS);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d  = {keptRem, 1'b0};
                quot_d = {quot_q[QW-2:0], qBit};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(QW-1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                flags_d = '0;
                if (expOver) begin
                    c_d              = {sign_q, INF_MAG};
                    flags_d[FLAG_OF] = 1'b1;
                end else if (expUnder) begin
                    c_d              = {sign_q, {(WORD_W-1){1'b0}}};
                    flags_d[FLAG_UF] = 1'b1;
                end else begin
                    c_d = {sign_q, expRnd[EXP_W-1:0], mantRnd[MAN_W-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any divide in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fpd_iter.sv
// tb_fpd_iter: self-checking bench for fpd_iter. A cycle-level reference model
// built from plain integer division tracks every transaction; directed vectors
// carry hand-computed results. Define FPD_ROUND_EN to match a rounding build.
module tb_fpd_iter;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;

    fpd_iter_if bus ();

    fpd_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] cTrunc;
        logic [31:0] cRound;
        logic [3:0]  flags;
        int          lat;
        int          hold;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // Reference: quotient as floor(ma * 2^25 / mb) with the result rules applied on top.
    function automatic void modelDivide(input logic [31:0] av, input logic [31:0] bv,
                                        output logic [31:0] cv, output logic [3:0] fv, output int lat);
        int              ea, eb, e;
        int unsigned     fa, fb, mant;
        bit              s, aZero, bZero, aInf, bInf, aNan, bNan;
        longint unsigned num, den, q;
        ea    = int'(av[30:23]);
        eb    = int'(bv[30:23]);
        fa    = 32'(av[22:0]);
        fb    = 32'(bv[22:0]);
        s     = av[31] ^ bv[31];
        aZero = (ea == 0);
        bZero = (eb == 0);
        aInf  = (ea == 255) && (fa == 0);
        bInf  = (eb == 255) && (fb == 0);
        aNan  = (ea == 255) && (fa != 0);
        bNan  = (eb == 255) && (fb != 0);
        fv    = 4'b0000;
        lat   = 2;
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            cv = 32'h7FC0_0000;
            fv = 4'b1000;
        end else if (aInf) begin
            cv = {s, 31'h7F80_0000};
        end else if (bZero) begin
            cv = {s, 31'h7F80_0000};
            fv = 4'b0100;
        end else if (aZero || bInf) begin
            cv = {s, 31'h0};
        end else begin
            lat = 29;
            num = 64'(fa | 32'h0080_0000) << 25;
            den = 64'(fb | 32'h0080_0000);
            q   = num / den;
            e   = ea - eb + 127;
            if (q < 64'h0200_0000) begin
                q = q << 1;
                e = e - 1;
            end
            mant = 32'((q >> 2) & 64'h7F_FFFF);
`ifdef FPD_ROUND_EN
            if (q[1] && (q[0] || ((num % den) != 0) || mant[0])) begin
                mant++;
                if (mant == 32'h0080_0000) begin
                    mant = 0;
                    e    = e + 1;
                end
            end
`endif
            if (e >= 255) begin
                cv = {s, 31'h7F80_0000};
                fv = 4'b0010;
            end else if (e <= 0) begin
                cv = {s, 31'h0};
                fv = 4'b0001;
            end else begin
                cv = {s, e[7:0], mant[22:0]};
            end
        end
    endfunction

    // Compare process: every falling edge, DUT handshake and result against the model.
    initial begin : compareProc
        bit          busy;
        bit          expValid;
        int          cyc;
        int          acceptCycle;
        int          mLat;
        logic [31:0] mC;
        logic [3:0]  mF;
        busy        = 1'b0;
        cyc         = 0;
        acceptCycle = 0;
        mLat        = 0;
        mC          = '0;
        mF          = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                busy = 1'b0;
                checkOutput("reset out_valid", {31'h0, bus.out_valid}, 32'h0);
                checkOutput("reset in_ready", {31'h0, bus.in_ready}, 32'h1);
                checkOutput("reset c", bus.c, 32'h0);
                checkOutput("reset flags", {28'h0, bus.flags}, 32'h0);
            end else begin
                expValid = busy && ((cyc - acceptCycle) >= mLat);
                checkOutput("model in_ready", {31'h0, bus.in_ready}, {31'h0, !busy});
                checkOutput("model out_valid", {31'h0, bus.out_valid}, {31'h0, expValid});
                if (expValid) begin
                    checkOutput("model c", bus.c, mC);
                    checkOutput("model flags", {28'h0, bus.flags}, {28'h0, mF});
                end
                if (expValid && bus.out_ready) begin
                    busy = 1'b0;
                end else if (!busy && bus.in_valid) begin
                    modelDivide(bus.a, bus.b, mC, mF, mLat);
                    busy        = 1'b1;
                    acceptCycle = cyc;
                end
            end
        end
    end

    // Drive one operation, hold back the result if asked, and check against literals.
    task automatic applyStimulus(input vec_t v, input string name);
        logic [31:0] expC;
        int          lat;
        expC = v.cTrunc;
`ifdef FPD_ROUND_EN
        expC = v.cRound;
`endif
        lat = 0;
        while (!bus.in_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.a         = v.a;
        bus.b         = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (v.hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({name, " c"}, bus.c, expC);
        checkOutput({name, " flags"}, {28'h0, bus.flags}, {28'h0, v.flags});
        for (int i = 0; i < v.hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h4100_0000;
            bus.b        = 32'h4000_0000;
            @(posedge clk);
            #1;
            checkOutput({name, " held c"}, bus.c, expC);
            checkOutput({name, " held flags"}, {28'h0, bus.flags}, {28'h0, v.flags});
            checkOutput({name, " held in_ready"}, {31'h0, bus.in_ready}, 32'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, " in_ready after"}, {31'h0, bus.in_ready}, 32'h1);
    endtask

    // Main sequence: reset, directed vectors, backpressure, abort by reset.
    initial begin : mainProc
        vec_t vecs[15];
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        #1;
        checkOutput("init in_ready", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("init out_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("init c", bus.c, 32'h0);
        checkOutput("init flags", {28'h0, bus.flags}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        vecs[0]  = '{32'h4100_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 4'b0000, 29, 0};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 32'h3EAA_AAAB, 4'b0000, 29, 0};
        vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0100, 2, 0};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000, 2, 0};
        vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0010, 29, 0};
        vecs[5]  = '{32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 29, 0};
        vecs[6]  = '{32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h3FC0_0000, 4'b0000, 29, 5};
        vecs[7]  = '{32'hC100_0000, 32'h4000_0000, 32'hC080_0000, 32'hC080_0000, 4'b0000, 29, 0};
        vecs[8]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0000, 2, 0};
        vecs[9]  = '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 2, 0};
        vecs[10] = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000, 2, 0};
        vecs[11] = '{32'hBF80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0100, 2, 0};
        vecs[12] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 2, 0};
        vecs[13] = '{32'hFF00_0000, 32'h3E80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0010, 29, 0};
        vecs[14] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000, 2, 0};

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        bus.a        = 32'h4100_0000;
        bus.b        = 32'h4000_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("abort in_ready", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("abort out_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("abort c", bus.c, 32'h0);
        checkOutput("abort flags", {28'h0, bus.flags}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(vecs[0], "post-reset 8/2");

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
